// File: rtl/bht_local_hist_if.sv
// Fetch-side predictor bus: lookup of the fetch PC plus the resolved-branch
// training channel from execute.
interface bht_local_hist_if #(
    parameter int XLEN = 32
);
    // No handshake: every upd_valid_i pulse is consumed in the cycle it is
    // presented, and the lookup answer is combinational from vpc_i.
    logic            flush_i;
    logic [XLEN-1:0] vpc_i;
    logic            pred_valid_o;
    logic            pred_taken_o;
    logic            upd_valid_i;
    logic [XLEN-1:0] upd_pc_i;
    logic            upd_taken_i;

    modport master (
        output flush_i, vpc_i, upd_valid_i, upd_pc_i, upd_taken_i,
        input  pred_valid_o, pred_taken_o
    );

    modport slave (
        input  flush_i, vpc_i, upd_valid_i, upd_pc_i, upd_taken_i,
        output pred_valid_o, pred_taken_o
    );
endinterface

// File: rtl/bht_local_hist.sv
// Two-level local-history branch predictor: per-entry history selects one of
// 2^BHT_HIST two-bit saturating counters; combinational lookup, one-cycle training.
module bht_local_hist #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 32,
    parameter int BHT_HIST    = 3,
    parameter int PC_OFFSET   = 1
) (
    input logic             clk_i,
    input logic             rst_i,
    bht_local_hist_if.slave bht
);
    localparam int IDX_W   = $clog2(BHT_ENTRIES);
    localparam int NUM_CTR = 1 << BHT_HIST;

    typedef logic [1:0] ctr_t;

    logic [BHT_ENTRIES-1:0] valid_q, valid_d;
    logic [BHT_HIST-1:0]    hist_q [BHT_ENTRIES];
    logic [BHT_HIST-1:0]    hist_d [BHT_ENTRIES];
    ctr_t                   ctr_q  [BHT_ENTRIES][NUM_CTR];
    ctr_t                   ctr_d  [BHT_ENTRIES][NUM_CTR];

    logic [IDX_W-1:0]    lkp_idx, upd_idx;
    logic [BHT_HIST-1:0] lkp_hist, upd_hist;
    ctr_t                lkp_ctr, upd_ctr, upd_ctr_new;
    logic [BHT_HIST:0]   upd_hist_shift;

    // No tag check: PCs that differ only above the index bits share an entry.
    assign lkp_idx = bht.vpc_i[PC_OFFSET +: IDX_W];
    assign upd_idx = bht.upd_pc_i[PC_OFFSET +: IDX_W];

    always_comb begin
        lkp_hist = hist_q[lkp_idx];
        lkp_ctr  = ctr_q[lkp_idx][lkp_hist];
    end

    assign bht.pred_valid_o = valid_q[lkp_idx];
    assign bht.pred_taken_o = valid_q[lkp_idx] & lkp_ctr[1];

    // Counter is picked with the pre-shift history of the same cycle.
    always_comb begin
        upd_hist    = hist_q[upd_idx];
        upd_ctr     = ctr_q[upd_idx][upd_hist];
        upd_ctr_new = upd_ctr;
        if (bht.upd_taken_i && (upd_ctr != 2'b11)) begin
            upd_ctr_new = upd_ctr + 2'b01;
        end else if (!bht.upd_taken_i && (upd_ctr != 2'b00)) begin
            upd_ctr_new = upd_ctr - 2'b01;
        end
        // Low BHT_HIST bits of {hist, outcome} are the shifted history, also for BHT_HIST = 1.
        upd_hist_shift = {upd_hist, bht.upd_taken_i};
    end

    always_comb begin
        valid_d = valid_q;
        hist_d  = hist_q;
        ctr_d   = ctr_q;
        if (bht.flush_i) begin
            // Counters survive a flush so retraining starts from learned bias.
            valid_d = '0;
            for (int e = 0; e < BHT_ENTRIES; e++) begin
                hist_d[e] = '0;
            end
        end else if (bht.upd_valid_i) begin
            valid_d[upd_idx]           = 1'b1;
            hist_d[upd_idx]            = upd_hist_shift[BHT_HIST-1:0];
            ctr_d[upd_idx][upd_hist]   = upd_ctr_new;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int e = 0; e < BHT_ENTRIES; e++) begin
                hist_q[e] <= '0;
                for (int c = 0; c < NUM_CTR; c++) begin
                    ctr_q[e][c] <= 2'b01;
                end
            end
        end else begin
            valid_q <= valid_d;
            hist_q  <= hist_d;
            ctr_q   <= ctr_d;
        end
    end
endmodule
